dm_arbiter: RTL and testbench
=============================

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have parameter LOCK_MAX, default 16, meaning the maximum consecutive cycles one master may hold a lock.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports mX_req, mX_we, mX_lock  input  1 each (X=0 CPU data port, X=1 DMA/debug port): request, write, hold-ownership.
REQ-005 SHALL have ports mX_addr  input  32, mX_be  input  4, mX_wdata  input  32: byte address, byte enables, pre-lane-aligned write data.
REQ-006 SHALL have ports mX_gnt  output  1, mX_rvalid  output  1, mX_rdata  output  32: grant, read-data-valid, read data.
REQ-007 SHALL have ports mem_en  output  1, mem_we  output  4, mem_addr  output  32, mem_wdata  output  32: shared synchronous DM port with per-byte write enable.
REQ-008 SHALL have port mem_rdata  input  32: DM read data, valid one cycle after a read enable.

Function
REQ-009 SHALL grant at most one master per cycle; gnt is combinational, in the same cycle as req.
REQ-010 SHALL drive mem_en=1, mem_addr, mem_wdata from the granted master; mem_en=0 and mem_we=0 when no grant.
REQ-011 SHALL drive mem_we=mX_be when the granted mX_we=1, else 4'b0000; a write with be=0 is granted and is a no-op.
REQ-012 SHALL complete a write in its grant cycle; no response beyond gnt.
REQ-013 SHALL assert mX_rvalid (registered) exactly one cycle after a read grant to X, otherwise 0; mX_rdata=mem_rdata for both masters.
REQ-014 SHALL implement FSM states IDLE, OWN0, OWN1.
REQ-015 IDLE: single requester SHALL be granted; with both requesting, the master selected by the round-robin pointer rr SHALL be granted.
REQ-016 On every grant in IDLE, rr SHALL move to the non-granted master.
REQ-017 IDLE->OWNx SHALL occur when X is granted with mX_lock=1; lock_cnt loads 1.
REQ-018 OWNx: only X SHALL be grantable; the other master's gnt=0 regardless of req; cycles without mX_req produce no access.
REQ-019 OWNx: lock_cnt SHALL increment every cycle; stay while mX_lock=1 and lock_cnt<LOCK_MAX.
REQ-020 OWNx->IDLE SHALL occur when mX_lock=0 (a request in that cycle is still granted to X) or when lock_cnt reaches LOCK_MAX (forced release); on exit rr points to the other master.
REQ-021 After forced release, X SHALL NOT re-enter OWNx before the other master is granted once, if the other master is requesting.
REQ-022 lock_cnt SHALL be ceil(log2(LOCK_MAX+1)) bits wide and SHALL saturate, never wrap.
REQ-023 A pending rvalid SHALL be delivered even if the FSM changes state in the same cycle.

Reset
REQ-024 While reset=1: state=IDLE, rr=0 (m0 first), lock_cnt=0, m0_rvalid=m1_rvalid=0, all gnt=0, mem_en=0, mem_we=0.
REQ-025 Reset asserted mid-read SHALL drop the pending rvalid; no rvalid after release.
REQ-026 First cycle after release SHALL arbitrate normally from IDLE.

Structure
REQ-027 Shared package SHALL hold the state encoding (IDLE/OWN0/OWN1) and the LOCK_MAX default constant.
REQ-028 Sub-module dm_rr_pick (combinational: two reqs + rr -> one-hot grant) SHALL perform the IDLE choice.
REQ-029 Read-return owner tracking and lock_cnt SHALL live in dm_arbiter.

Verification
REQ-030 Reset release, m0 read addr 0x10, mem_rdata=0xDEADBEEF -> m0_gnt same cycle, m0_rvalid=1 next cycle, m0_rdata=0xDEADBEEF, m1_rvalid=0.
REQ-031 Both request continuously from reset -> grants alternate m0,m1,m0,m1; mem_addr follows the granted master.
REQ-032 m1 write be=4'b0100, wdata=0x00AB0000 -> mem_we=4'b0100, mem_wdata=0x00AB0000; be=0 -> mem_we=0, m1_gnt=1.
REQ-033 m0 lock held 40 cycles while m1 requests, LOCK_MAX=16 -> m1_gnt=0 for 16 cycles, then m1 granted before m0 again.
REQ-034 m0 lock dropped at cycle 3 -> m0 granted that cycle; m1 granted next cycle.
REQ-035 Reset pulsed the cycle after an m1 read grant -> m1_rvalid stays 0; state IDLE, rr=0.

Source files
------------

// File: rtl/dm_arbiter_pkg.sv
// dm_arbiter_pkg: shared FSM encoding and default lock bound for the DM arbiter
package dm_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;
    localparam int LOCK_MAX_DEF = 16;
endpackage

// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: both master ports plus the shared data-memory port
interface dm_arbiter_if;
    logic        m0_req, m0_we, m0_lock;
    logic [31:0] m0_addr, m0_wdata;
    logic [3:0]  m0_be;
    logic        m0_gnt, m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m1_req, m1_we, m1_lock;
    logic [31:0] m1_addr, m1_wdata;
    logic [3:0]  m1_be;
    logic        m1_gnt, m1_rvalid;
    logic [31:0] m1_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    modport slave (
        input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata, m0_be,
        input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_be,
        output m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );
    modport master (
        output m0_req, m0_we, m0_lock, m0_addr, m0_wdata, m0_be,
        output m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_be,
        input  m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dm_rr_pick.sv
// dm_rr_pick: one-hot choice between two requesters; rr names the preferred master on a tie
module dm_rr_pick (
    input  logic [1:0] req,
    input  logic       rr,
    output logic [1:0] gnt
);
    assign gnt[0] = req[0] & (~req[1] | ~rr);
    assign gnt[1] = req[1] & (~req[0] | rr);
endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-master data-memory arbiter with round-robin choice and bounded bus locking
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int LOCK_MAX = LOCK_MAX_DEF
) (
    input logic         clk,
    input logic         reset,
    dm_arbiter_if.slave bus
);
    localparam int CW = $clog2(LOCK_MAX + 1);
    state_t        state, state_n;
    logic          rr, rr_n, own;
    logic [CW-1:0] lock_cnt, cnt_n, cnt_inc;
    logic [1:0]    req, we, lock, pick, gnt, g, rvalid;
    assign req  = {bus.m1_req, bus.m0_req};
    assign we   = {bus.m1_we, bus.m0_we};
    assign lock = {bus.m1_lock, bus.m0_lock};
    dm_rr_pick u_pick (.req(req), .rr(rr), .gnt(pick));
    assign own     = (state == OWN1);
    assign cnt_inc = (lock_cnt == CW'(LOCK_MAX)) ? lock_cnt : lock_cnt + 1'b1;
    always_comb begin
        state_n = state;
        rr_n    = rr;
        cnt_n   = lock_cnt;
        gnt     = '0;
        if (state == IDLE) begin
            gnt     = pick;
            rr_n    = (|pick) ? pick[0] : rr;
            cnt_n   = ((|(pick & lock)) && LOCK_MAX > 1) ? CW'(1) : '0;
            state_n = ((|(pick & lock)) && LOCK_MAX > 1) ? (pick[1] ? OWN1 : OWN0) : IDLE;
        end else begin
            gnt[own] = req[own];
            cnt_n    = cnt_inc;
            // release on dropped lock or once the owner has held LOCK_MAX cycles
            if (!lock[own] || cnt_inc == CW'(LOCK_MAX)) begin
                state_n = IDLE;
                rr_n    = ~own;
            end
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rr       <= 1'b0;
            lock_cnt <= '0;
            rvalid   <= '0;
        end else begin
            state    <= state_n;
            rr       <= rr_n;
            lock_cnt <= cnt_n;
            rvalid   <= g & ~we;
        end
    end
    assign g              = reset ? 2'b00 : gnt;
    assign bus.m0_gnt     = g[0];
    assign bus.m1_gnt     = g[1];
    assign bus.mem_en     = |g;
    assign bus.mem_addr   = g[1] ? bus.m1_addr : bus.m0_addr;
    assign bus.mem_wdata  = g[1] ? bus.m1_wdata : bus.m0_wdata;
    assign bus.mem_we     = (|(g & we)) ? (g[1] ? bus.m1_be : bus.m0_be) : 4'b0000;
    assign bus.m0_rvalid  = rvalid[0];
    assign bus.m1_rvalid  = rvalid[1];
    assign bus.m0_rdata   = bus.mem_rdata;
    assign bus.m1_rdata   = bus.mem_rdata;
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: vector table, lock/reset corner sequences and a randomized run against a reference model
module tb_dm_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int errors = 0;
    int checks = 0;
    dm_arbiter_if bus ();
    dm_arbiter #(.LOCK_MAX(16)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        logic r0, w0, r1, w1;
        logic [31:0] a0, a1, d0, d1;
        logic [3:0] b0, b1;
        logic g0, g1;
        logic [3:0] we;
        logic rv0, rv1;
    } vec_t;
    vec_t v[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive0(input logic r, w, l, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        bus.m0_req = r; bus.m0_we = w; bus.m0_lock = l;
        bus.m0_addr = a; bus.m0_be = b; bus.m0_wdata = d;
    endtask

    task automatic drive1(input logic r, w, l, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        bus.m1_req = r; bus.m1_we = w; bus.m1_lock = l;
        bus.m1_addr = a; bus.m1_be = b; bus.m1_wdata = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string t, input logic g0, g1, input logic [3:0] we,
                             input logic [31:0] addr, wd, input logic rv0, rv1, input logic [31:0] rd);
        #4;
        chk({t, " m0_gnt"}, 32'(bus.m0_gnt), 32'(g0));
        chk({t, " m1_gnt"}, 32'(bus.m1_gnt), 32'(g1));
        chk({t, " mem_en"}, 32'(bus.mem_en), 32'(g0 | g1));
        chk({t, " mem_we"}, 32'(bus.mem_we), 32'(we));
        if (g0 | g1) begin
            chk({t, " mem_addr"}, bus.mem_addr, addr);
            chk({t, " mem_wdata"}, bus.mem_wdata, wd);
        end
        chk({t, " m0_rvalid"}, 32'(bus.m0_rvalid), 32'(rv0));
        chk({t, " m1_rvalid"}, 32'(bus.m1_rvalid), 32'(rv1));
        if (rv0) chk({t, " m0_rdata"}, bus.m0_rdata, rd);
        if (rv1) chk({t, " m1_rdata"}, bus.m1_rdata, rd);
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        drive0(0, 0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        v[0]  = '{1, 0, 0, 0, 'h10,  'h0,   0,          0,          0,    0,       1, 0, 4'h0,    0, 0};
        v[1]  = '{0, 0, 0, 0, 'h0,   'h0,   0,          0,          0,    0,       0, 0, 4'h0,    1, 0};
        v[2]  = '{1, 0, 1, 0, 'h100, 'h200, 0,          0,          0,    0,       0, 1, 4'h0,    0, 0};
        v[3]  = '{1, 0, 1, 0, 'h100, 'h200, 0,          0,          0,    0,       1, 0, 4'h0,    0, 1};
        v[4]  = '{1, 0, 1, 0, 'h100, 'h200, 0,          0,          0,    0,       0, 1, 4'h0,    1, 0};
        v[5]  = '{1, 0, 1, 0, 'h100, 'h200, 0,          0,          0,    0,       1, 0, 4'h0,    0, 1};
        v[6]  = '{0, 0, 1, 1, 'h0,   'h40,  0,          'h00AB0000, 0,    4'b0100, 0, 1, 4'b0100, 1, 0};
        v[7]  = '{0, 0, 1, 1, 'h0,   'h44,  0,          'h00CD0000, 0,    4'b0000, 0, 1, 4'b0000, 0, 0};
        v[8]  = '{1, 1, 1, 0, 'h8,   'h50,  'h12345678, 0,          4'hF, 0,       1, 0, 4'hF,    0, 0};
        v[9]  = '{0, 0, 0, 0, 'h0,   'h0,   0,          0,          0,    0,       0, 0, 4'h0,    0, 0};
        v[10] = '{0, 0, 1, 0, 'h0,   'h60,  0,          0,          0,    0,       0, 1, 4'h0,    0, 0};
        v[11] = '{0, 0, 0, 0, 'h0,   'h0,   0,          0,          0,    0,       0, 0, 4'h0,    0, 1};
        bus.mem_rdata = 32'hDEADBEEF;
        drive0(1, 0, 1, 'h10, 0, 0);
        drive1(1, 0, 1, 'h20, 0, 0);
        check_out("in_reset", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive0(v[i].r0, v[i].w0, 0, v[i].a0, v[i].b0, v[i].d0);
            drive1(v[i].r1, v[i].w1, 0, v[i].a1, v[i].b1, v[i].d1);
            check_out($sformatf("vec%0d", i), v[i].g0, v[i].g1, v[i].we,
                      v[i].g1 ? v[i].a1 : v[i].a0, v[i].g1 ? v[i].d1 : v[i].d0,
                      v[i].rv0, v[i].rv1, 32'hDEADBEEF);
            tick();
        end
        // m0 holds lock throughout: m1 wins once every 17 cycles
        reset_pulse();
        for (int c = 0; c < 40; c++) begin
            drive0(1, 0, 1, 'h100, 0, 0);
            drive1(1, 0, 0, 'h200, 0, 0);
            check_out($sformatf("lock_max%0d", c), c % 17 != 16, c % 17 == 16, 0,
                      (c % 17 == 16) ? 32'h200 : 32'h100, 0,
                      c > 0 && (c - 1) % 17 != 16, c > 0 && (c - 1) % 17 == 16, 32'hDEADBEEF);
            tick();
        end
        reset_pulse();
        for (int c = 0; c < 6; c++) begin
            drive0(c != 2, 0, c < 3, 'h300, 0, 0);
            drive1(1, 0, 0, 'h400, 0, 0);
            check_out($sformatf("lock_drop%0d", c), c != 2 && c != 4, c == 4, 0,
                      (c == 4) ? 32'h400 : 32'h300, 0, c == 1 || c == 2 || c == 4, c == 5, 32'hDEADBEEF);
            tick();
        end
        reset_pulse();
        drive0(0, 0, 0, 0, 0, 0);
        drive1(1, 0, 0, 'h500, 0, 0);
        check_out("mid_rd_grant", 0, 1, 0, 'h500, 0, 0, 0, 0);
        tick();
        reset = 1'b1;
        drive1(0, 0, 0, 0, 0, 0);
        check_out("mid_rd_reset", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
        drive0(1, 0, 0, 'h600, 0, 0);
        drive1(1, 0, 0, 'h700, 0, 0);
        check_out("post_rst0", 1, 0, 0, 'h600, 0, 0, 0, 0);
        tick();
        check_out("post_rst1", 0, 1, 0, 'h700, 0, 1, 0, 32'hDEADBEEF);
        tick();
        reset_pulse();
        begin
            int own = -1, pref = 0, held = 0, g;
            logic pv0 = 0, pv1 = 0;
            logic r[2], w[2], l[2];
            logic [31:0] a[2], d[2], mrd;
            logic [3:0] b[2];
            for (int c = 0; c < 1500; c++) begin
                for (int m = 0; m < 2; m++) begin
                    r[m] = $urandom_range(0, 7) != 0;
                    w[m] = $urandom_range(0, 1) == 1;
                    l[m] = $urandom_range(0, 15) != 0;
                    a[m] = $urandom;
                    d[m] = $urandom;
                    b[m] = 4'($urandom);
                end
                mrd = $urandom;
                drive0(r[0], w[0], l[0], a[0], b[0], d[0]);
                drive1(r[1], w[1], l[1], a[1], b[1], d[1]);
                bus.mem_rdata = mrd;
                g = -1;
                if (own < 0) g = (r[0] && r[1]) ? pref : r[0] ? 0 : r[1] ? 1 : -1;
                else if (r[own]) g = own;
                check_out($sformatf("rnd%0d", c), g == 0, g == 1,
                          (g >= 0 && w[g]) ? b[g] : 4'h0, g >= 0 ? a[g] : 0, g >= 0 ? d[g] : 0,
                          pv0, pv1, mrd);
                pv0 = g == 0 && !w[0];
                pv1 = g == 1 && !w[1];
                if (own < 0) begin
                    if (g >= 0) begin
                        pref = 1 - g;
                        if (l[g]) begin
                            own = g;
                            held = 1;
                        end
                    end
                end else begin
                    held++;
                    if (!l[own] || held >= 16) begin
                        pref = 1 - own;
                        own = -1;
                    end
                end
                tick();
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
